// File: rtl/run_controller.sv
// Host-side START/DONE sequencer: runs NUM_PROGS programs per GO and reports each run's cycle count.
// Latency: GO is registered, so LAUNCH begins two edges after GO is seen; all outputs are registered.
// Backpressure: none; GO is ignored outside IDLE/FINISH. Watchdog compiled in with RUN_CTRL_TIMEOUT_EN.
module run_controller #(
    parameter int NUM_PROGS      = 3,
    parameter int START_CYCLES   = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                                             CLK,
    input  logic                                             RESET,
    input  logic                                             GO,
    input  logic                                             DONE,
    output logic                                             START,
    output logic [$clog2((NUM_PROGS > 1) ? NUM_PROGS : 2)-1:0] PROG_SEL,
    output logic                                             BUSY,
    output logic [CNT_W-1:0]                                 CYCLES,
    output logic                                             RUN_VALID,
    output logic                                             ALL_DONE,
    output logic                                             TIMEOUT_ERR
);

    localparam int PW = $clog2((NUM_PROGS > 1) ? NUM_PROGS : 2);
    localparam int LW = $clog2((START_CYCLES > 1) ? START_CYCLES : 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [PW-1:0] LAST_SEL    = PW'(NUM_PROGS - 1);
    localparam logic [LW-1:0] LAUNCH_LAST = LW'(START_CYCLES - 1);

    // The watchdog limit must be reachable by the run counter.
    if ((longint'(TIMEOUT_CYCLES) >> CNT_W) != 0) begin : g_timeout_range
        $error("TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    logic [2:0]       state_q, state_d;
    logic             go_q, go_d;
    logic [PW-1:0]    prog_sel_q, prog_sel_d;
    logic [LW-1:0]    launch_cnt_q, launch_cnt_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic             abort_q, abort_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             run_valid_q, run_valid_d;
    logic             all_done_q, all_done_d;
    logic             timeout_hit;
    logic [CNT_W-1:0] timeout_val;

`ifdef RUN_CTRL_TIMEOUT_EN
    assign timeout_hit = (run_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_val = CNT_W'(TIMEOUT_CYCLES);
`else
    // No watchdog: RUN waits for DONE indefinitely and abort_q never sets.
    assign timeout_hit = 1'b0;
    assign timeout_val = '0;
`endif

    // Next-state and datapath; outputs are derived from the next state so they come straight off flops.
    always_comb begin
        state_d      = state_q;
        go_d         = GO && ((state_q == S_IDLE) || (state_q == S_FINISH));
        prog_sel_d   = prog_sel_q;
        launch_cnt_d = launch_cnt_q;
        run_cnt_d    = run_cnt_q;
        cycles_d     = cycles_q;
        abort_d      = abort_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (go_q) begin
                    state_d      = S_LAUNCH;
                    prog_sel_d   = '0;
                    launch_cnt_d = '0;
                    abort_d      = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (launch_cnt_q == LAUNCH_LAST) begin
                    state_d   = S_RUN;
                    run_cnt_d = CNT_W'(1);
                end else begin
                    launch_cnt_d = launch_cnt_q + LW'(1);
                end
            end
            S_RUN: begin
                // DONE takes priority over a simultaneous watchdog expiry.
                if (DONE) begin
                    state_d  = S_RECORD;
                    cycles_d = run_cnt_q;
                end else if (timeout_hit) begin
                    state_d  = S_RECORD;
                    cycles_d = timeout_val;
                    abort_d  = 1'b1;
                end else if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
            end
            S_RECORD: begin
                if (abort_q || (prog_sel_q == LAST_SEL)) begin
                    state_d = S_FINISH;
                end else begin
                    state_d      = S_LAUNCH;
                    prog_sel_d   = prog_sel_q + PW'(1);
                    launch_cnt_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        start_d     = (state_d == S_LAUNCH);
        busy_d      = (state_d == S_LAUNCH) || (state_d == S_RUN) || (state_d == S_RECORD);
        run_valid_d = (state_d == S_RECORD);
        all_done_d  = (state_d == S_FINISH);
    end

    // State and output registers; reset clears everything immediately, dropping START asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            go_q         <= 1'b0;
            prog_sel_q   <= '0;
            launch_cnt_q <= '0;
            run_cnt_q    <= '0;
            cycles_q     <= '0;
            abort_q      <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            run_valid_q  <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            go_q         <= go_d;
            prog_sel_q   <= prog_sel_d;
            launch_cnt_q <= launch_cnt_d;
            run_cnt_q    <= run_cnt_d;
            cycles_q     <= cycles_d;
            abort_q      <= abort_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            run_valid_q  <= run_valid_d;
            all_done_q   <= all_done_d;
        end
    end

    assign START       = start_q;
    assign PROG_SEL    = prog_sel_q;
    assign BUSY        = busy_q;
    assign CYCLES      = cycles_q;
    assign RUN_VALID   = run_valid_q;
    assign ALL_DONE    = all_done_q;
    assign TIMEOUT_ERR = abort_q;

endmodule
